// File: rtl/powerup_pkg.sv
// ============================================================================
// powerup_pkg : shared slot states, register offsets and hidden coordinate
// Revision    : 1.0
// ============================================================================
`default_nettype none

package powerup_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ARMED  = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;

    localparam int OFF_X          = 0;
    localparam int OFF_Y          = 1;
    localparam int OFF_STAT       = 2;
    localparam int OFF_STAGE      = 3;
    localparam int WORDS_PER_SLOT = 4;

    // Sliced down to COORD_W at the point of use; moves the sprite off-screen.
    localparam logic [63:0] HIDDEN_COORD = {64{1'b1}};

endpackage

`default_nettype wire

// File: rtl/powerup_slot.sv
// ============================================================================
// powerup_slot : one power-up slot - position, state, pickup detect, timer
// Revision     : 1.0
// ============================================================================
`default_nettype none

module powerup_slot
    import powerup_pkg::*;
#(
    parameter int NUM_PLAYERS = 2,
    parameter int COORD_W     = 32,
    parameter int SPRITE_W    = 25,
    parameter int SPRITE_H    = 25,
    parameter int TICK_DIV    = 100000000,
    parameter int NUM_STAGES  = 8
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           wr_x,
    input  logic                           wr_y,
    input  logic                           wr_cancel,
    input  logic [COORD_W-1:0]             wcoord,
    input  logic [NUM_PLAYERS*COORD_W-1:0] player_x,
    input  logic [NUM_PLAYERS*COORD_W-1:0] player_y,
    output logic [1:0]                     state,
    output logic [COORD_W-1:0]             pos_x,
    output logic [COORD_W-1:0]             pos_y,
    output logic [COORD_W-1:0]             disp_x,
    output logic [COORD_W-1:0]             disp_y,
    output logic [2:0]                     holder,
    output logic [31:0]                    stage,
    output logic                           pickup
);

    localparam int TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int STAGE_W = $clog2(NUM_STAGES + 1);
    localparam logic [TICK_W-1:0]  TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [COORD_W:0]   EXT_W     = (COORD_W+1)'(SPRITE_W);
    localparam logic [COORD_W:0]   EXT_H     = (COORD_W+1)'(SPRITE_H);

    logic [1:0]         state_q,  state_d;
    logic [COORD_W-1:0] x_q,      x_d;
    logic [COORD_W-1:0] y_q,      y_d;
    logic [2:0]         holder_q, holder_d;
    logic [TICK_W-1:0]  tick_q,   tick_d;
    logic [STAGE_W-1:0] stage_q,  stage_d;
    logic               pickup_q, pickup_d;

    logic [NUM_PLAYERS-1:0] overlap;
    logic                   hit;
    logic [2:0]             hit_idx;

    // Sums carry one extra bit so a sprite near the top of the range cannot wrap.
    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_overlap
        logic [COORD_W:0] px, py, ux, uy;
        assign px = {1'b0, player_x[p*COORD_W +: COORD_W]};
        assign py = {1'b0, player_y[p*COORD_W +: COORD_W]};
        assign ux = {1'b0, x_q};
        assign uy = {1'b0, y_q};
        assign overlap[p] = (px <= ux + EXT_W) && (ux <= px + EXT_W) &&
                            (py <= uy + EXT_H) && (uy <= py + EXT_H);
    end

    always_comb begin
        hit     = 1'b0;
        hit_idx = 3'd0;
        for (int p = NUM_PLAYERS - 1; p >= 0; p--) begin
            if (overlap[p]) begin
                hit     = 1'b1;
                hit_idx = 3'(p);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        holder_d = holder_q;
        tick_d   = tick_q;
        stage_d  = stage_q;
        pickup_d = 1'b0;
        if (wr_cancel) begin
            state_d  = ST_IDLE;
            holder_d = 3'd0;
            tick_d   = '0;
            stage_d  = '0;
        end else begin
            case (state_q)
                ST_ARMED: begin
                    if (hit) begin
                        state_d  = ST_ACTIVE;
                        holder_d = hit_idx;
                        stage_d  = STAGE_W'(NUM_STAGES);
                        tick_d   = '0;
                        pickup_d = 1'b1;
                    end else begin
                        if (wr_x) x_d = wcoord;
                        if (wr_y) y_d = wcoord;
                    end
                end
                ST_ACTIVE: begin
                    if (wr_x) x_d = wcoord;
                    if (wr_y) y_d = wcoord;
                    if (tick_q == TICK_LAST) begin
                        tick_d  = '0;
                        stage_d = stage_q - 1'b1;
                        if (stage_q == STAGE_W'(1)) state_d = ST_IDLE;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                default: begin
                    if (wr_x) x_d = wcoord;
                    if (wr_y) begin
                        y_d     = wcoord;
                        state_d = ST_ARMED;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            x_q      <= '0;
            y_q      <= '0;
            holder_q <= 3'd0;
            tick_q   <= '0;
            stage_q  <= '0;
            pickup_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            holder_q <= holder_d;
            tick_q   <= tick_d;
            stage_q  <= stage_d;
            pickup_q <= pickup_d;
        end
    end

    assign state  = state_q;
    assign pos_x  = x_q;
    assign pos_y  = y_q;
    assign disp_x = (state_q == ST_ARMED) ? x_q : HIDDEN_COORD[COORD_W-1:0];
    assign disp_y = (state_q == ST_ARMED) ? y_q : HIDDEN_COORD[COORD_W-1:0];
    assign holder = holder_q;
    assign stage  = 32'(stage_q);
    assign pickup = pickup_q;

endmodule

`default_nettype wire

// File: rtl/powerup_manager.sv
// ============================================================================
// powerup_manager : bus-mapped array of power-up slots with per-player effects
// Revision        : 1.0
// ============================================================================
`default_nettype none

module powerup_manager
    import powerup_pkg::*;
#(
    parameter int NUM_PLAYERS  = 2,
    parameter int NUM_POWERUPS = 2,
    parameter int COORD_W      = 32,
    parameter int SPRITE_W     = 25,
    parameter int SPRITE_H     = 25,
    parameter int TICK_DIV     = 100000000,
    parameter int NUM_STAGES   = 8,
    parameter int AW           = 17,
    parameter int BASE_ADDR    = 4300
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [AW-1:0]                   addr,
    input  logic                            wren,
    input  logic [31:0]                     wdata,
    output logic [31:0]                     rdata,
    input  logic [NUM_PLAYERS*COORD_W-1:0]  player_x,
    input  logic [NUM_PLAYERS*COORD_W-1:0]  player_y,
    output logic [NUM_POWERUPS*COORD_W-1:0] powerup_x,
    output logic [NUM_POWERUPS*COORD_W-1:0] powerup_y,
    output logic [NUM_PLAYERS*NUM_POWERUPS-1:0] effect,
    output logic [NUM_POWERUPS-1:0]         pickup
);

    localparam int SLOT_WORDS = WORDS_PER_SLOT * NUM_POWERUPS;
    localparam int WIN_WORDS  = SLOT_WORDS + NUM_PLAYERS;

    logic [AW-1:0]      off;
    logic               in_win;
    logic               wr_en;
    logic [COORD_W-1:0] wcoord;
    logic [31:0]        rdata_q, rdata_d;

    logic [1:0]         slot_state  [NUM_POWERUPS];
    logic [COORD_W-1:0] slot_x      [NUM_POWERUPS];
    logic [COORD_W-1:0] slot_y      [NUM_POWERUPS];
    logic [2:0]         slot_holder [NUM_POWERUPS];
    logic [31:0]        slot_stage  [NUM_POWERUPS];
    logic [NUM_POWERUPS-1:0] held   [NUM_PLAYERS];

    assign off    = addr - AW'(BASE_ADDR);
    assign in_win = (addr >= AW'(BASE_ADDR)) && (off < AW'(WIN_WORDS));
    assign wr_en  = wren && in_win;
    assign wcoord = COORD_W'(wdata);

    for (genvar k = 0; k < NUM_POWERUPS; k++) begin : g_slot
        localparam int SB = WORDS_PER_SLOT * k;
        logic [COORD_W-1:0] disp_x, disp_y;

        powerup_slot #(
            .NUM_PLAYERS (NUM_PLAYERS),
            .COORD_W     (COORD_W),
            .SPRITE_W    (SPRITE_W),
            .SPRITE_H    (SPRITE_H),
            .TICK_DIV    (TICK_DIV),
            .NUM_STAGES  (NUM_STAGES)
        ) u_slot (
            .clock     (clock),
            .reset     (reset),
            .wr_x      (wr_en && (off == AW'(SB + OFF_X))),
            .wr_y      (wr_en && (off == AW'(SB + OFF_Y))),
            .wr_cancel (wr_en && (off == AW'(SB + OFF_STAT))),
            .wcoord    (wcoord),
            .player_x  (player_x),
            .player_y  (player_y),
            .state     (slot_state[k]),
            .pos_x     (slot_x[k]),
            .pos_y     (slot_y[k]),
            .disp_x    (disp_x),
            .disp_y    (disp_y),
            .holder    (slot_holder[k]),
            .stage     (slot_stage[k]),
            .pickup    (pickup[k])
        );

        assign powerup_x[k*COORD_W +: COORD_W] = disp_x;
        assign powerup_y[k*COORD_W +: COORD_W] = disp_y;
    end

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
        for (genvar k = 0; k < NUM_POWERUPS; k++) begin : g_held
            assign held[p][k] = (slot_state[k] == ST_ACTIVE) && (slot_holder[k] == 3'(p));
            assign effect[p*NUM_POWERUPS + k] = held[p][k];
        end
    end

    // Reads see pre-edge state, so a same-cycle write is not yet visible.
    always_comb begin
        rdata_d = rdata_q;
        if (in_win) begin
            rdata_d = 32'd0;
            for (int k = 0; k < NUM_POWERUPS; k++) begin
                if (off == AW'(WORDS_PER_SLOT*k + OFF_X))     rdata_d = 32'(slot_x[k]);
                if (off == AW'(WORDS_PER_SLOT*k + OFF_Y))     rdata_d = 32'(slot_y[k]);
                if (off == AW'(WORDS_PER_SLOT*k + OFF_STAT))  rdata_d = {21'd0, slot_holder[k], 6'd0, slot_state[k]};
                if (off == AW'(WORDS_PER_SLOT*k + OFF_STAGE)) rdata_d = slot_stage[k];
            end
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                if (off == AW'(SLOT_WORDS + p)) rdata_d = 32'(held[p]);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) rdata_q <= 32'd0;
        else        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_powerup_manager.sv
// ============================================================================
// tb_powerup_manager : directed self-checking bench for powerup_manager
// Revision           : 1.0
// ============================================================================
`default_nettype none

module tb_powerup_manager;

    localparam int NP   = 2;
    localparam int NU   = 2;
    localparam int BASE = 4300;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [16:0]   addr  = '0;
    logic          wren  = 1'b0;
    logic [31:0]   wdata = '0;
    logic [31:0]   rdata;
    logic [63:0]   player_x, player_y;
    logic [63:0]   powerup_x, powerup_y;
    logic [3:0]    effect;
    logic [1:0]    pickup;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] rd;
    int cnt;

    powerup_manager #(
        .NUM_PLAYERS(NP), .NUM_POWERUPS(NU), .COORD_W(32), .SPRITE_W(25), .SPRITE_H(25),
        .TICK_DIV(4), .NUM_STAGES(2), .AW(17), .BASE_ADDR(BASE)
    ) dut (
        .clock(clock), .reset(reset), .addr(addr), .wren(wren), .wdata(wdata), .rdata(rdata),
        .player_x(player_x), .player_y(player_y), .powerup_x(powerup_x), .powerup_y(powerup_y),
        .effect(effect), .pickup(pickup)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_player(input int p, input logic [31:0] x, input logic [31:0] y);
        player_x[p*32 +: 32] = x;
        player_y[p*32 +: 32] = y;
    endtask

    task automatic bus_write(input int a, input logic [31:0] d);
        addr = 17'(a); wdata = d; wren = 1'b1;
        @(negedge clock);
        wren = 1'b0;
    endtask

    task automatic bus_read(input int a, output logic [31:0] d);
        addr = 17'(a); wren = 1'b0;
        @(negedge clock);
        d = rdata;
    endtask

    task automatic players_home();
        set_player(0, 260, 240);
        set_player(1, 360, 240);
    endtask

    initial begin
        players_home();
        repeat (3) @(negedge clock);
        check("reset_effect", effect, 0);
        check("reset_pickup", pickup, 0);
        check("reset_rdata", rdata, 0);
        check("reset_powerup_x", powerup_x, 64'hFFFF_FFFF_FFFF_FFFF);
        reset = 1'b1;
        @(negedge clock);

        bus_read(BASE + 2, rd); check("rst_stat0", rd, 0);
        bus_read(BASE + 0, rd); check("rst_x0", rd, 0);
        bus_read(BASE + 8, rd); check("rst_pl0", rd, 0);
        bus_read(BASE + 9, rd); check("rst_pl1", rd, 0);

        // Spawn clear of both players
        bus_write(BASE + 0, 300);
        bus_write(BASE + 1, 300);
        check("spawn_px", powerup_x[31:0], 300);
        check("spawn_py", powerup_y[31:0], 300);
        repeat (3) @(negedge clock);
        check("spawn_no_pickup", pickup, 0);
        bus_read(BASE + 2, rd); check("spawn_stat", rd, 1);
        bus_read(BASE + 0, rd); check("spawn_xread", rd, 300);

        // Player 0 walks onto slot 0
        set_player(0, 276, 276);
        @(negedge clock);
        check("pick_pulse", pickup, 2'b01);
        check("pick_effect", effect, 4'b0001);
        check("pick_hidden_x", powerup_x[31:0], 32'hFFFF_FFFF);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (!effect[0]) break;
            cnt++;
            if (i == 0) addr = 17'(BASE + 2);
            if (i == 1) begin
                check("pick_pulse_end", pickup, 0);
                check("pick_stat_active", rdata, 32'h0000_0002);
                addr = 17'(BASE + 8);
            end
            if (i == 2) check("pick_pl0_mask", rdata, 1);
            @(negedge clock);
        end
        check("effect_cycles", cnt, 8);
        bus_read(BASE + 2, rd); check("expire_state", rd[1:0], 0);
        players_home();
        @(negedge clock);

        // Both players land on the slot together: player 0 wins
        bus_write(BASE + 0, 300);
        bus_write(BASE + 1, 300);
        set_player(0, 300, 300);
        set_player(1, 300, 300);
        @(negedge clock);
        check("both_effect", effect, 4'b0001);
        bus_read(BASE + 2, rd); check("both_stat", rd, 32'h0000_0002);
        bus_read(BASE + 9, rd); check("both_pl1", rd, 0);
        players_home();
        bus_write(BASE + 2, 0);
        check("cancel_effect", effect, 0);
        bus_read(BASE + 2, rd); check("cancel_stat", rd, 0);

        // Cancel races pickup on slot 1
        bus_write(BASE + 4, 500);
        bus_write(BASE + 5, 500);
        bus_read(BASE + 6, rd); check("s1_armed", rd, 1);
        set_player(1, 500, 500);
        bus_write(BASE + 6, 0);
        check("race_pickup", pickup, 0);
        check("race_effect", effect, 0);
        bus_read(BASE + 6, rd); check("race_stat", rd, 0);
        players_home();

        // Reset in the middle of an activation
        bus_write(BASE + 0, 300);
        bus_write(BASE + 1, 300);
        set_player(0, 276, 276);
        @(negedge clock);
        check("mid_effect_on", effect, 4'b0001);
        #1 reset = 1'b0;
        #1;
        check("mid_rst_effect", effect, 0);
        check("mid_rst_pickup", pickup, 0);
        check("mid_rst_px", powerup_x, 64'hFFFF_FFFF_FFFF_FFFF);
        players_home();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        // Edge touch: px = ux+25 overlaps
        bus_write(BASE + 0, 300);
        bus_write(BASE + 1, 300);
        set_player(0, 325, 300);
        @(negedge clock);
        check("touch25_pickup", pickup, 2'b01);
        players_home();
        bus_write(BASE + 2, 0);
        // One pixel further: no overlap
        bus_write(BASE + 0, 300);
        bus_write(BASE + 1, 300);
        set_player(0, 326, 300);
        @(negedge clock);
        check("touch26_pickup", pickup, 0);
        repeat (2) @(negedge clock);
        bus_read(BASE + 2, rd); check("touch26_stat", rd, 1);
        check("touch26_effect", effect, 0);

        // Out-of-window read holds rdata; unmapped-in-window does not exist here
        bus_read(BASE + 0, rd); check("hold_pre", rd, 300);
        bus_read(BASE - 1, rd); check("hold_outside", rd, 300);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
